// File: rtl/rand_range_gen.sv
// rtl/rand_range_gen.sv - LFSR random source with run-time seed, range bounds and valid/ready output
module rand_range_gen #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
    parameter logic [WIDTH-1:0] SEED      = 4'b0010,
    parameter int               MODE      = 0,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_out
);

    localparam logic [7:0] TRIES = 8'(MAX_TRIES);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] low_b;
    logic [WIDTH-1:0] high_b;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] out_next;
    logic             feedback;
    logic             in_range;
    logic             accepting;
    logic             take;
    logic             load_out;
    logic [7:0]       miss;
    logic [7:0]       miss_inc;
    logic [7:0]       miss_next;

    // Order the bounds so a swapped lo/hi pair describes the same range, then clamp the candidate.
    always_comb begin
        low_b    = (lo <= hi) ? lo : hi;
        high_b   = (lo <= hi) ? hi : lo;
        in_range = (lfsr >= low_b) && (lfsr <= high_b);
        if (lfsr < low_b) begin
            clamped = low_b;
        end else if (lfsr > high_b) begin
            clamped = high_b;
        end else begin
            clamped = lfsr;
        end
        feedback  = ^(lfsr & TAPS);
        accepting = !rand_valid || rand_ready;
        take      = enable && !seed_load && accepting;
        miss_inc  = miss + 8'd1;
    end

    // Decide whether the current candidate becomes the next output or counts as a rejected draw.
    always_comb begin
        load_out  = 1'b0;
        out_next  = clamped;
        miss_next = miss;
        if (take) begin
            if (MODE == 0) begin
                load_out = 1'b1;
            end else if (in_range) begin
                load_out  = 1'b1;
                out_next  = lfsr;
                miss_next = 8'd0;
            end else if (miss_inc >= TRIES) begin
                load_out  = 1'b1;
                miss_next = 8'd0;
            end else begin
                miss_next = miss_inc;
            end
        end
    end

    // LFSR state: reseed has priority over stepping; an all-zero state recovers to SEED on the next step.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? SEED : seed_in;
        end else if (enable) begin
            lfsr <= (lfsr == '0) ? SEED : {lfsr[WIDTH-2:0], feedback};
        end
    end

    // Output register: holds an unconsumed value until transfer; seed_load flushes validity but keeps the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rand_valid <= 1'b0;
            rand_out   <= '0;
            miss       <= 8'd0;
        end else if (seed_load) begin
            rand_valid <= 1'b0;
            miss       <= 8'd0;
        end else begin
            miss <= miss_next;
            if (load_out) begin
                rand_out   <= out_next;
                rand_valid <= 1'b1;
            end else if (rand_ready) begin
                rand_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rand_range_gen.sv
// tb/tb_rand_range_gen.sv - scoreboard bench for rand_range_gen
module tb_rand_range_gen;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       seed_load;
    logic [3:0] seed_in;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       rand_ready;
    logic       rand_valid;
    logic [3:0] rand_out;

    logic       v1;
    logic [3:0] o1;
    logic       v2;
    logic [3:0] o2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int q0[$];
    int seen[$];

    logic [3:0] m_lfsr;
    logic       m_valid;

    int n1 = 0;
    int n2 = 0;
    int last2 = 0;
    int exp1 [2] = '{4, 6};
    int tbl [16] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 13, 13, 12, 8, 2, 2};

    rand_range_gen u_dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .lo(lo), .hi(hi), .rand_ready(rand_ready), .rand_valid(rand_valid), .rand_out(rand_out)
    );

    rand_range_gen #(.MODE(1), .MAX_TRIES(4)) u_rej (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .lo(4'd4), .hi(4'd6), .rand_ready(1'b1), .rand_valid(v1), .rand_out(o1)
    );

    rand_range_gen #(.MODE(1), .MAX_TRIES(2)) u_fb (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .lo(4'd0), .hi(4'd0), .rand_ready(1'b1), .rand_valid(v2), .rand_out(o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        if (s == 4'd0) return 4'd2;
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic int clamp_ref(input int x, input int a, input int b);
        int l;
        int h;
        l = (a < b) ? a : b;
        h = (a < b) ? b : a;
        if (x < l) return l;
        if (x > h) return h;
        return x;
    endfunction

    // One clock: compare handshakes seen now, advance the reference, then step past the edge.
    task automatic tick();
        if (rand_valid && rand_ready) begin
            check_eq("xfer_pending", int'(q0.size() > 0), 1);
            if (q0.size() > 0) check_eq("xfer_value", int'(rand_out), q0.pop_front());
            seen.push_back(int'(rand_out));
        end
        check_eq("valid", int'(rand_valid), int'(m_valid));
        if (v1 && n1 < 2) begin
            check_eq("rej_value", int'(o1), exp1[n1]);
            n1++;
        end
        if (v2 && n2 < 4) begin
            check_eq("fallback_value", int'(o2), 0);
            if (n2 > 0) check_eq("fallback_gap", cyc - last2, 2);
            last2 = cyc;
            n2++;
        end
        if (reset) begin
            m_lfsr  = 4'd2;
            m_valid = 1'b0;
            q0.delete();
        end else if (seed_load) begin
            m_lfsr  = (seed_in == 4'd0) ? 4'd2 : seed_in;
            m_valid = 1'b0;
            q0.delete();
        end else if (enable) begin
            if (!m_valid || rand_ready) begin
                m_valid = 1'b1;
                q0.push_back(clamp_ref(int'(m_lfsr), int'(lo), int'(hi)));
            end
            m_lfsr = lfsr_step(m_lfsr);
        end else if (m_valid && rand_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_table(input string tag);
        check_eq({tag, "_count"}, int'(seen.size() >= 16), 1);
        for (int i = 0; i < 16 && i < seen.size(); i++) check_eq(tag, seen[i], tbl[i]);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        seed_load  = 1'b0;
        seed_in    = 4'd0;
        lo         = 4'd2;
        hi         = 4'd13;
        rand_ready = 1'b1;
        m_lfsr     = 4'd2;
        m_valid    = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        check_eq("reset_valid", int'(rand_valid), 0);
        check_eq("reset_out", int'(rand_out), 0);

        reset  = 1'b0;
        enable = 1'b1;
        seen.delete();
        repeat (18) tick();
        check_table("default_seq");
        check_eq("rej_count", n1, 2);
        check_eq("fallback_count", n2, 4);

        seed_load = 1'b1;
        seed_in   = 4'd2;
        tick();
        seed_load = 1'b0;
        for (int i = 0; i < 5 && !rand_valid; i++) tick();
        check_eq("bp_first_valid", int'(rand_valid), 1);
        rand_ready = 1'b0;
        repeat (5) begin
            tick();
            check_eq("bp_hold_out", int'(rand_out), 2);
            check_eq("bp_hold_valid", int'(rand_valid), 1);
        end
        rand_ready = 1'b1;
        seen.delete();
        repeat (10) tick();
        check_eq("bp_count", int'(seen.size() >= 3), 1);
        if (seen.size() >= 3) begin
            check_eq("bp_release_held", seen[0], 2);
            check_eq("bp_release_next", seen[1], 10);
            check_eq("bp_release_after", seen[2], 5);
        end

        seed_load = 1'b1;
        seed_in   = 4'd0;
        tick();
        seed_load = 1'b0;
        check_eq("zero_seed_valid", int'(rand_valid), 0);
        seen.delete();
        repeat (4) tick();
        check_eq("zero_seed_count", int'(seen.size() >= 2), 1);
        if (seen.size() >= 2) begin
            check_eq("zero_seed_first", seen[0], 2);
            check_eq("zero_seed_second", seen[1], 4);
        end

        enable = 1'b0;
        repeat (3) tick();
        check_eq("stall_valid", int'(rand_valid), 0);
        lo     = 4'd13;
        hi     = 4'd2;
        enable = 1'b1;
        repeat (6) tick();

        seed_load = 1'b1;
        seed_in   = 4'd2;
        tick();
        seed_load = 1'b0;
        seen.delete();
        repeat (17) tick();
        check_table("swapped_seq");

        rand_ready = 1'b0;
        for (int i = 0; i < 5 && !rand_valid; i++) tick();
        check_eq("mid_valid_before_reset", int'(rand_valid), 1);
        reset = 1'b1;
        tick();
        check_eq("mid_reset_valid", int'(rand_valid), 0);
        check_eq("mid_reset_out", int'(rand_out), 0);
        reset      = 1'b0;
        rand_ready = 1'b1;
        seen.delete();
        repeat (4) tick();
        check_eq("post_reset_count", int'(seen.size() >= 1), 1);
        if (seen.size() >= 1) check_eq("post_reset_first", seen[0], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
